// File: rtl/eot_pkg.sv
// Shared types and constants for the EOT-framed serial transmitter.
package eot_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } fifo_entry_t;

  localparam logic [BYTE_W-1:0] EOT_BYTE_DEFAULT = 8'h04;

endpackage

// File: rtl/eot_frame_tx_if.sv
// Byte write port (valid/ready) feeding the frame transmitter.
interface eot_frame_tx_if;
  import eot_pkg::*;

  logic [BYTE_W-1:0] wr_data;
  logic              wr_frame_end;
  logic              wr_valid;
  logic              wr_ready;

  modport master (output wr_data, output wr_frame_end, output wr_valid, input wr_ready);
  modport slave  (input wr_data, input wr_frame_end, input wr_valid, output wr_ready);
endinterface

// File: rtl/eot_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and combinational head read.
module eot_sync_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = logic [8:0]
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t pop_data_c,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_d;
  logic               do_push;
  logic               do_pop;

  assign do_push    = push & ~full;
  assign do_pop     = pop & ~empty;
  assign pop_data_c = mem[rd_ptr];

  always_comb begin
    count_d = count;
    case ({do_push, do_pop})
      2'b10:   count_d = count + CNT_W'(1);
      2'b01:   count_d = count - CNT_W'(1);
      default: count_d = count;
    endcase
  end

  // Storage carries no reset; only the pointers and flags define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      empty <= (count_d == '0);
    end
  end

endmodule

// File: rtl/eot_frame_tx.sv
// 8N1 LSB-first serial transmitter; appends EOT_BYTE after each frame_end byte.
module eot_frame_tx
  import eot_pkg::*;
#(
  parameter int unsigned       CLK_DIV    = 104,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [BYTE_W-1:0] EOT_BYTE   = EOT_BYTE_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  eot_frame_tx_if.slave wr,
  output logic          tx,
  output logic          busy,
  output logic          frame_done
);

  localparam int unsigned      CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  tx_state_t         state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [2:0]        bit_idx, bit_idx_d;
  logic [BYTE_W-1:0] shift, shift_d;
  logic              last_q, last_d;
  logic              is_eot_q, is_eot_d;
  logic              eot_pending, eot_pending_d;
  logic              done_q, done_d;
  logic              run_q;
  logic              bit_end;
  logic              push, pop;
  logic              fifo_full, fifo_empty;
  fifo_entry_t       push_entry, pop_entry;

  // Writes are refused until the first clock after reset release.
  assign wr.wr_ready = ena & run_q & ~fifo_full;
  assign push        = wr.wr_valid & wr.wr_ready;
  assign push_entry  = '{last: wr.wr_frame_end, data: wr.wr_data};
  assign bit_end     = (cnt == CNT_LAST);

  eot_sync_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fifo_entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .pop_data_c (pop_entry),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      last_q      <= 1'b0;
      is_eot_q    <= 1'b0;
      eot_pending <= 1'b0;
      done_q      <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      bit_idx     <= bit_idx_d;
      shift       <= shift_d;
      last_q      <= last_d;
      is_eot_q    <= is_eot_d;
      eot_pending <= eot_pending_d;
      done_q      <= done_d;
      run_q       <= 1'b1;
    end
  end

  // Next-state: pending EOT wins over a FIFO pop; pops stop while ena is low.
  always_comb begin
    state_d       = state;
    cnt_d         = cnt + CNT_W'(1);
    bit_idx_d     = bit_idx;
    shift_d       = shift;
    last_d        = last_q;
    is_eot_d      = is_eot_q;
    eot_pending_d = eot_pending;
    done_d        = 1'b0;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (eot_pending) begin
          shift_d  = EOT_BYTE;
          last_d   = 1'b0;
          is_eot_d = 1'b1;
          state_d  = START;
        end else if (!fifo_empty && ena) begin
          pop      = 1'b1;
          shift_d  = pop_entry.data;
          last_d   = pop_entry.last;
          is_eot_d = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift[BYTE_W-1:1]};
          if (bit_idx == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (is_eot_q) begin
            eot_pending_d = 1'b0;
            done_d        = 1'b1;
          end else if (last_q) begin
            eot_pending_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line and status registers trail the FSM by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tx         <= (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
      busy       <= (state != IDLE) | eot_pending | ~fifo_empty;
      frame_done <= done_q;
    end
  end

endmodule

// File: tb/tb_eot_frame_tx.sv
// Directed bench for eot_frame_tx at CLK_DIV=4, FIFO_DEPTH=4.
module tb_eot_frame_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic tx, busy, frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt = 0;
  logic [7:0] rx_q[$];

  eot_frame_tx_if bus ();

  eot_frame_tx #(.CLK_DIV(4), .FIFO_DEPTH(4), .EOT_BYTE(8'h04)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .wr         (bus),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  // Line decoder: samples each bit near its middle and collects bytes.
  always begin
    logic [7:0] rx_byte;
    @(negedge clk);
    if (rst_n === 1'b1 && tx === 1'b0) begin
      repeat (2) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
        repeat (4) @(negedge clk);
        rx_byte[b] = tx;
      end
      repeat (4) @(negedge clk);
      n_cmp++;
      if (tx !== 1'b1) begin
        n_bad++;
        $display("FAIL rx_stop: got %b want 1", tx);
      end
      rx_q.push_back(rx_byte);
    end
  end

  task automatic wr_byte(input logic [7:0] d, input logic fe);
    int t = 0;
    @(negedge clk);
    bus.wr_data = d;
    bus.wr_frame_end = fe;
    bus.wr_valid = 1'b1;
    while (bus.wr_ready !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      n_cmp++; n_bad++;
      $display("FAIL wr_timeout: data %h not accepted", d);
    end
    @(posedge clk);
  endtask

  task automatic wr_idle();
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (bus.wr_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", bus.wr_ready); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.wr_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %b want 1", bus.wr_ready); end
  endtask

  task automatic test_single_byte();
    logic [7:0] exp = 8'hA5;
    rx_q.delete();
    fd_cnt = 0;
    wr_byte(exp, 1'b0);
    wr_idle();
    @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL latency_n1: got %b want 1", tx); end
    @(negedge clk);
    n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL latency_n2: got %b want 0", tx); end
    repeat (2) @(negedge clk);
    n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL start_mid: got %b want 0", tx); end
    for (int b = 0; b < 8; b++) begin
      repeat (4) @(negedge clk);
      n_cmp++;
      if (tx !== exp[b]) begin n_bad++; $display("FAIL a5_bit%0d: got %b want %b", b, tx, exp[b]); end
    end
    repeat (4) @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL a5_stop: got %b want 1", tx); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_cycle40: got %b want 1", busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_cycle41: got %b want 0", busy); end
    repeat (5) @(negedge clk);
    n_cmp++; if (rx_q.size() != 1) begin n_bad++; $display("FAIL a5_count: got %0d want 1", rx_q.size()); end
    else begin
      n_cmp++; if (rx_q[0] !== exp) begin n_bad++; $display("FAIL a5_rx: got %h want %h", rx_q[0], exp); end
    end
    n_cmp++; if (fd_cnt != 0) begin n_bad++; $display("FAIL a5_no_fd: got %0d want 0", fd_cnt); end
  endtask

  task automatic test_frame();
    logic [7:0] exp [3] = '{8'h31, 8'h32, 8'h04};
    int t = 0;
    rx_q.delete();
    fd_cnt = 0;
    wr_byte(8'h31, 1'b0);
    wr_byte(8'h32, 1'b1);
    wr_idle();
    while (frame_done !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    n_cmp++; if (t >= 300) begin n_bad++; $display("FAIL frame_fd_timeout: got no pulse want pulse"); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL frame_busy_at_fd: got %b want 0", busy); end
    @(negedge clk);
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL frame_fd_width: got %b want 0", frame_done); end
    repeat (10) @(negedge clk);
    n_cmp++; if (fd_cnt != 1) begin n_bad++; $display("FAIL frame_fd_count: got %0d want 1", fd_cnt); end
    n_cmp++;
    if (rx_q.size() != 3) begin n_bad++; $display("FAIL frame_count: got %0d want 3", rx_q.size()); end
    else if (rx_q[0] !== exp[0] || rx_q[1] !== exp[1] || rx_q[2] !== exp[2]) begin
      n_bad++;
      $display("FAIL frame_rx: got %h %h %h want 31 32 04", rx_q[0], rx_q[1], rx_q[2]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [6] = '{8'h10, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    int t = 0;
    logic ok = 1'b1;
    rx_q.delete();
    wr_byte(8'h10, 1'b0);
    wr_idle();
    repeat (3) @(negedge clk);
    for (int i = 1; i < 5; i++) wr_byte(exp[i], 1'b0);
    @(negedge clk);
    bus.wr_data = exp[5];
    bus.wr_frame_end = 1'b0;
    n_cmp++; if (bus.wr_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", bus.wr_ready); end
    while (bus.wr_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    n_cmp++; if (t < 20 || t >= 100) begin n_bad++; $display("FAIL full_hold: ready after %0d cycles want 20..99", t); end
    @(posedge clk);
    wr_idle();
    t = 0;
    while (busy !== 1'b0 && t < 400) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (rx_q.size() != 6) begin n_bad++; $display("FAIL b2b_count: got %0d want 6", rx_q.size()); end
    else begin
      for (int i = 0; i < 6; i++) if (rx_q[i] !== exp[i]) ok = 1'b0;
      if (!ok) begin
        n_bad++;
        $display("FAIL b2b_order: got %h %h %h %h %h %h want 10 41 42 43 44 45",
                 rx_q[0], rx_q[1], rx_q[2], rx_q[3], rx_q[4], rx_q[5]);
      end
    end
  endtask

  task automatic test_ena_drop();
    int t = 0;
    rx_q.delete();
    fd_cnt = 0;
    wr_byte(8'h50, 1'b0);
    wr_byte(8'h51, 1'b1);
    wr_byte(8'h52, 1'b0);
    wr_idle();
    while (rx_q.size() < 1 && t < 200) begin @(negedge clk); t++; end
    repeat (10) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.wr_ready !== 1'b0) begin n_bad++; $display("FAIL ena_ready: got %b want 0", bus.wr_ready); end
    t = 0;
    while (frame_done !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    n_cmp++; if (t >= 200) begin n_bad++; $display("FAIL ena_fd_timeout: got no pulse want pulse"); end
    repeat (60) @(negedge clk);
    n_cmp++;
    if (rx_q.size() != 3) begin n_bad++; $display("FAIL ena_hold_count: got %0d want 3", rx_q.size()); end
    else if (rx_q[0] !== 8'h50 || rx_q[1] !== 8'h51 || rx_q[2] !== 8'h04) begin
      n_bad++;
      $display("FAIL ena_hold_rx: got %h %h %h want 50 51 04", rx_q[0], rx_q[1], rx_q[2]);
    end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ena_busy_queued: got %b want 1", busy); end
    n_cmp++; if (fd_cnt != 1) begin n_bad++; $display("FAIL ena_fd_count: got %0d want 1", fd_cnt); end
    ena = 1'b1;
    t = 0;
    while (busy !== 1'b0 && t < 200) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (rx_q.size() != 4) begin n_bad++; $display("FAIL ena_resume_count: got %0d want 4", rx_q.size()); end
    else if (rx_q[3] !== 8'h52) begin n_bad++; $display("FAIL ena_resume_rx: got %h want 52", rx_q[3]); end
  endtask

  task automatic test_reset_mid();
    logic stayed = 1'b1;
    fd_cnt = 0;
    wr_byte(8'h60, 1'b1);
    wr_byte(8'h61, 1'b0);
    wr_idle();
    repeat (19) @(negedge clk);
    n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL rst_pre_bit3: got %b want 0", tx); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL rst_async_tx: got %b want 1", tx); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) stayed = 1'b0;
    end
    n_cmp++; if (!stayed) begin n_bad++; $display("FAIL rst_quiet: got activity want idle line, busy=0"); end
    n_cmp++; if (fd_cnt != 0) begin n_bad++; $display("FAIL rst_no_fd: got %0d want 0", fd_cnt); end
    n_cmp++; if (bus.wr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", bus.wr_ready); end
    rx_q.delete();
  endtask

  initial begin
    bus.wr_data = 8'h00;
    bus.wr_frame_end = 1'b0;
    bus.wr_valid = 1'b0;
    test_reset();
    test_single_byte();
    test_frame();
    test_back_to_back();
    test_ena_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
